// File: rtl/task_8_pkg.sv
// task_8_pkg: shared definitions for the task 8 input-side buffer.
//   task_input_enum   : receive/replay state machine encoding
//   NUM_WORDS_DEFAULT : default maximum stored payload bytes per packet
//   SIZE_W            : width of byte counters and the packet size status
package task_8_pkg;

    localparam int SIZE_W            = 12;
    localparam int NUM_WORDS_DEFAULT = 81;

    typedef enum logic [1:0] {
        s_IDLE    = 2'd0,
        s_RECEIVE = 2'd1,
        s_DRAIN   = 2'd2,
        s_SEND    = 2'd3
    } task_input_enum;

endpackage

// File: rtl/task_8_sync_fifo.sv
// task_8_sync_fifo: single-clock first-word-fall-through FIFO.
//   i_clk, i_rst : clock, synchronous active-high flush
//   wr_en, din   : push din when not full
//   rd_en        : pop the head when not empty
//   dout         : current head (zero while empty)
//   empty, full  : occupancy flags
module task_8_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 128
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when addresses match.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    always_ff @(posedge i_clk) begin
        if (wr_en && !full) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (wr_en && !full) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (rd_en && !empty) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign dout  = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/task_8_in.sv
// task_8_in: input-side buffer for task 8. Collects one request packet from
// the task manager, stores at most NUM_WORDS bytes (excess dropped and
// flagged), then replays the stored bytes to the core with a last marker.
//   i_clk, i_rst                         : clock, synchronous active-high reset
//   i_tmanager_data/_valid/_last         : request byte stream from manager
//   o_tmanager_ready                     : manager byte accepted this cycle
//   i_core_ready                         : core consumes o_data this cycle
//   o_data, o_data_valid, o_input_last   : replay stream to core
//   o_busy, o_overflow                   : packet in progress / bytes dropped
//   o_packet_size_in_bytes               : stored byte count while replaying
// Handshake: a byte moves on either side exactly in a cycle where its valid
// and ready are both high at the rising edge; valid never waits on ready.
module task_8_in
    import task_8_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_WORDS  = NUM_WORDS_DEFAULT,
    parameter int FIFO_DEPTH = 128
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_tmanager_data,
    input  logic                  i_tmanager_valid,
    input  logic                  i_tmanager_last,
    output logic                  o_tmanager_ready,
    input  logic                  i_core_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_valid,
    output logic                  o_input_last,
    output logic                  o_busy,
    output logic                  o_overflow,
    output logic [SIZE_W-1:0]     o_packet_size_in_bytes
);

    localparam logic [SIZE_W-1:0] c_num_words = SIZE_W'(NUM_WORDS);

    task_input_enum        r_state;
    task_input_enum        w_state_next;
    logic [SIZE_W-1:0]     r_wr_count;
    logic [SIZE_W-1:0]     r_rd_count;
    logic                  r_overflow;

    logic                  w_accept;
    logic                  w_wr_en;
    logic                  w_drop;
    logic                  w_pop;
    logic                  w_head_is_last;
    logic                  w_fifo_valid;
    logic                  w_empty;
    logic                  w_full;
    logic [DATA_WIDTH-1:0] w_dout;

    assign o_tmanager_ready = (r_state != s_SEND) && !i_rst;
    assign w_accept         = i_tmanager_valid && o_tmanager_ready;
    assign w_fifo_valid     = (r_state == s_SEND) && !w_empty;
    // Head is the final stored byte when exactly one stored byte is unread.
    assign w_head_is_last   = (r_rd_count == r_wr_count - SIZE_W'(1));

    always_comb begin
        w_state_next = r_state;
        w_wr_en      = 1'b0;
        w_drop       = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            s_IDLE: begin
                if (w_accept) begin
                    w_wr_en = 1'b1;
                    if (i_tmanager_last)          w_state_next = s_SEND;
                    else if (c_num_words == 1)    w_state_next = s_DRAIN;
                    else                          w_state_next = s_RECEIVE;
                end
            end
            s_RECEIVE: begin
                if (w_accept) begin
                    w_wr_en = (r_wr_count != c_num_words);
                    if (i_tmanager_last) begin
                        w_state_next = s_SEND;
                    end else if (r_wr_count + SIZE_W'(1) == c_num_words) begin
                        w_state_next = s_DRAIN;
                    end
                end
            end
            s_DRAIN: begin
                if (w_accept) begin
                    w_drop = 1'b1;
                    if (i_tmanager_last) w_state_next = s_SEND;
                end
            end
            s_SEND: begin
                w_pop = w_fifo_valid && i_core_ready;
                if (w_pop && w_head_is_last) w_state_next = s_IDLE;
            end
            default: w_state_next = s_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= s_IDLE;
            r_wr_count <= '0;
            r_rd_count <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_wr_en) begin
                r_wr_count <= r_wr_count + SIZE_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_pop) begin
                if (w_head_is_last) begin
                    r_wr_count <= '0;
                    r_rd_count <= '0;
                    r_overflow <= 1'b0;
                end else begin
                    r_rd_count <= r_rd_count + SIZE_W'(1);
                end
            end
        end
    end

    task_8_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .wr_en (w_wr_en && !w_full),
        .din   (i_tmanager_data),
        .rd_en (w_pop),
        .dout  (w_dout),
        .empty (w_empty),
        .full  (w_full)
    );

    assign o_data                 = w_dout;
    assign o_data_valid           = w_fifo_valid;
    assign o_input_last           = w_fifo_valid && w_head_is_last;
    assign o_busy                 = (r_state != s_IDLE);
    assign o_overflow             = r_overflow;
    assign o_packet_size_in_bytes = (r_state == s_SEND) ? r_wr_count : '0;

endmodule

// File: tb/tb_task_8_in.sv
module tb_task_8_in;

  localparam int DW = 8;
  localparam int NW = 81;
  localparam int FD = 128;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [DW-1:0] i_tmanager_data = '0;
  logic          i_tmanager_valid = 1'b0;
  logic          i_tmanager_last = 1'b0;
  logic          o_tmanager_ready;
  logic          i_core_ready = 1'b0;
  logic [DW-1:0] o_data;
  logic          o_data_valid;
  logic          o_input_last;
  logic          o_busy;
  logic          o_overflow;
  logic [11:0]   o_packet_size_in_bytes;

  int checks = 0;
  int errors = 0;

  // Reference model: bytes the core must see, in order, for the current packet.
  logic [DW-1:0] exp_q[$];
  logic          exp_ovf;
  logic [DW-1:0] pkt_q[$];

  task_8_in #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .FIFO_DEPTH(FD)) dut (
    .i_clk                  (i_clk),
    .i_rst                  (i_rst),
    .i_tmanager_data        (i_tmanager_data),
    .i_tmanager_valid       (i_tmanager_valid),
    .i_tmanager_last        (i_tmanager_last),
    .o_tmanager_ready       (o_tmanager_ready),
    .i_core_ready           (i_core_ready),
    .o_data                 (o_data),
    .o_data_valid           (o_data_valid),
    .o_input_last           (o_input_last),
    .o_busy                 (o_busy),
    .o_overflow             (o_overflow),
    .o_packet_size_in_bytes (o_packet_size_in_bytes)
  );

  // clock
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    i_rst = 1'b1;
    i_tmanager_valid = 1'b0;
    i_tmanager_last = 1'b0;
    i_core_ready = 1'b0;
    repeat (cycles) tick();
    chk("rst_ready", o_tmanager_ready, 0);
    chk("rst_valid", o_data_valid, 0);
    chk("rst_last", o_input_last, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_size", o_packet_size_in_bytes, 0);
    chk("rst_data", o_data, 0);
    i_rst = 1'b0;
    #1;
    chk("post_rst_ready", o_tmanager_ready, 1);
  endtask

  task automatic fill_seq(input logic [DW-1:0] base, input int n);
    pkt_q.delete();
    for (int i = 0; i < n; i++) pkt_q.push_back(base + DW'(i));
  endtask

  task automatic fill_rand(input int n);
    pkt_q.delete();
    for (int i = 0; i < n; i++) pkt_q.push_back(DW'($urandom));
  endtask

  // Drive pkt_q to the manager port and build the expected replay.
  task automatic send_pkt(input bit gaps);
    int n;
    n = pkt_q.size();
    exp_q.delete();
    exp_ovf = (n > NW);
    for (int i = 0; i < n; i++) begin
      if (i < NW) exp_q.push_back(pkt_q[i]);
      if (gaps && $urandom_range(0, 3) == 0) begin
        i_tmanager_valid = 1'b0;
        i_tmanager_data = DW'($urandom);
        tick();
      end
      i_tmanager_valid = 1'b1;
      i_tmanager_data = pkt_q[i];
      i_tmanager_last = (i == n - 1);
      chk("rx_ready", o_tmanager_ready, 1);
      chk("rx_ovf", o_overflow, (i > NW));
      chk("rx_busy", o_busy, (i > 0));
      chk("rx_valid", o_data_valid, 0);
      tick();
    end
    i_tmanager_valid = 1'b0;
    i_tmanager_last = 1'b0;
  endtask

  // mode 0: core always ready, 1: alternating, 2: random.
  task automatic recv_pkt(input int mode, input bit hold_valid, input logic [DW-1:0] next_byte);
    int cyc;
    int n_exp;
    bit rdy;
    cyc = 0;
    n_exp = exp_q.size();
    if (hold_valid) begin
      i_tmanager_valid = 1'b1;
      i_tmanager_data = next_byte;
      i_tmanager_last = 1'b0;
    end
    while (exp_q.size() > 0 && cyc < 4 * NW + 50) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      i_core_ready = rdy;
      chk("tx_valid", o_data_valid, 1);
      chk("tx_data", o_data, exp_q[0]);
      chk("tx_last", o_input_last, (exp_q.size() == 1));
      chk("tx_size", o_packet_size_in_bytes, n_exp);
      chk("tx_ovf", o_overflow, exp_ovf);
      chk("tx_mgr_ready", o_tmanager_ready, 0);
      chk("tx_busy", o_busy, 1);
      tick();
      if (rdy) void'(exp_q.pop_front());
      cyc++;
    end
    chk("tx_budget_left", exp_q.size(), 0);
    i_core_ready = 1'b0;
    chk("idle_busy", o_busy, 0);
    chk("idle_valid", o_data_valid, 0);
    chk("idle_size", o_packet_size_in_bytes, 0);
    chk("idle_ovf", o_overflow, 0);
    chk("idle_ready", o_tmanager_ready, 1);
  endtask

  initial begin
    do_reset(3);

    // Full-size packet, exactly NUM_WORDS bytes: no overflow.
    fill_seq(8'h01, 81);
    send_pkt(0);
    recv_pkt(0, 0, '0);

    // Short packet: valid one cycle after last accept.
    fill_seq(8'hA0, 3);
    send_pkt(0);
    recv_pkt(0, 0, '0);

    // Oversize packet: tail dropped, overflow flagged.
    fill_seq(8'h00, 90);
    send_pkt(0);
    recv_pkt(0, 0, '0);

    // Core stalls every other cycle.
    fill_seq(8'h60, 10);
    send_pkt(0);
    recv_pkt(1, 0, '0);

    // Manager holds valid through replay; next packet starts right after.
    fill_seq(8'h30, 4);
    send_pkt(0);
    recv_pkt(0, 1, 8'h40);
    fill_seq(8'h40, 3);
    send_pkt(0);
    recv_pkt(0, 0, '0);

    // Reset partway through a packet, then a fresh short packet.
    for (int i = 0; i < 40; i++) begin
      i_tmanager_valid = 1'b1;
      i_tmanager_data = DW'(i + 1);
      i_tmanager_last = 1'b0;
      tick();
    end
    do_reset(2);
    fill_seq(8'h10, 5);
    send_pkt(0);
    recv_pkt(0, 0, '0);

    // Boundaries: single byte, one past the limit.
    fill_rand(1);
    send_pkt(1);
    recv_pkt(2, 0, '0);
    fill_rand(82);
    send_pkt(1);
    recv_pkt(2, 0, '0);

    // Random lengths, gaps and core back-pressure.
    for (int p = 0; p < 6; p++) begin
      fill_rand($urandom_range(1, 100));
      send_pkt(1);
      recv_pkt(2, 0, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/task_8_in.md
# task_8_in

Input-side buffer for task 8, sitting between the task manager's byte stream and the task core. It accepts one request packet from the manager (valid/ready/last handshake) and stores up to NUM_WORDS bytes in a local FIFO, discarding and flagging any excess. Once the packet is complete it replays the stored bytes to the core with an input-last marker. It is the receive-side counterpart of the task 8 output stage and uses the same busy/packet-size status conventions.

## Interface
- DATA_WIDTH, 8, byte width on both sides
- NUM_WORDS, 81, maximum payload bytes stored per packet (1..4095)
- FIFO_DEPTH, 128, storage depth; power of two, >= NUM_WORDS
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high; flushes FIFO, state to s_IDLE
- i_tmanager_data  in  DATA_WIDTH  request byte from manager
- i_tmanager_valid  in  1  request byte valid
- i_tmanager_last  in  1  marks final byte of request packet
- o_tmanager_ready  out  1  block accepts a manager byte this cycle
- i_core_ready  in  1  core consumes o_data this cycle
- o_data  out  DATA_WIDTH  byte to core (FIFO head)
- o_data_valid  out  1  o_data valid
- o_input_last  out  1  o_data is the final stored byte of the packet
- o_busy  out  1  packet in progress
- o_overflow  out  1  packet exceeded NUM_WORDS; excess dropped
- o_packet_size_in_bytes  out  12  stored byte count of current packet

## Operation
- States: s_IDLE, s_RECEIVE, s_DRAIN, s_SEND.
- Manager transfer: byte accepted when i_tmanager_valid && o_tmanager_ready. o_tmanager_ready = (state is s_IDLE, s_RECEIVE or s_DRAIN) && !i_rst.
- s_IDLE: an accepted byte is written to the FIFO and sets wr_count to 1. Next state: s_SEND if last, s_DRAIN if NUM_WORDS==1, otherwise s_RECEIVE.
- s_RECEIVE: each accepted byte is written and increments wr_count. Last -> s_SEND. If wr_count reaches NUM_WORDS without last -> s_DRAIN.
- s_DRAIN: accepted bytes are discarded, not written. The first discarded byte sets o_overflow. An accepted last -> s_SEND.
- s_SEND: o_tmanager_ready=0. o_data_valid = FIFO not empty. A pop occurs on o_data_valid && i_core_ready, and increments rd_count. o_input_last = o_data_valid && (rd_count == wr_count-1). Popping the last byte -> s_IDLE. In the same edge, wr_count, rd_count and o_overflow clear.
- o_packet_size_in_bytes = wr_count while in s_SEND, 0 otherwise.
- o_busy = 1 in s_RECEIVE, s_DRAIN and s_SEND.
- Counters are 12-bit. wr_count saturates at NUM_WORDS, and no write is issued at that value.
- The FIFO can never be full in legal operation, because each packet has at most NUM_WORDS stored bytes and the FIFO is empty on entry to s_IDLE.

## Timing
- Reset values: o_tmanager_ready 0 (during i_rst), o_data_valid 0, o_input_last 0, o_busy 0, o_overflow 0, o_packet_size_in_bytes 0, o_data 0. o_tmanager_ready goes to 1 in the first cycle after i_rst deasserts.
- Reset mid-packet, in any state, drops all stored bytes and partial counts. The next accepted byte starts a new packet.
- Latency: last byte accepted at edge N. State is s_SEND, o_data_valid=1 and o_data is byte 0, all after edge N.
- The FIFO is first-word-fall-through: o_data holds the head and changes only after a pop. While i_core_ready=0, o_data and o_input_last stay stable.
- Manager valid during s_SEND is ignored; those bytes are not accepted and not lost by this block.
- Throughput is one byte per cycle on each side.

## Structure
- Package task_8_pkg holds:
  - the state enum task_input_enum;
  - the NUM_WORDS default;
  - localparam SIZE_W=12.
- Sub-module task_8_sync_fifo: single-clock FWFT FIFO with parameters WIDTH and DEPTH, and ports wr_en, din, rd_en, dout, empty, full.

## Test plan
- 81-byte packet 0x01..0x51, last on 0x51, core always ready -> 81 bytes out in order, o_input_last only with 0x51, size=81, o_overflow=0, then back to s_IDLE.
- 3-byte packet 0xA0,0xA1,0xA2 -> o_data_valid one cycle after the last accept, size=3, o_input_last with 0xA2.
- 90-byte packet 0x00..0x59 -> bytes 0x00..0x50 delivered, 0x51..0x59 dropped, o_overflow=1 from the cycle after 0x51 until s_IDLE, ready held high until last.
- 10-byte packet with i_core_ready alternating 1/0 -> no duplicated or lost bytes, o_data stable while not ready.
- Manager asserts valid continuously across s_SEND -> o_tmanager_ready=0 for the whole send. The second packet is accepted starting the cycle after the first packet's last pop.
- Reset after 40 of 81 bytes, then a 5-byte packet 0x10..0x14 -> only 0x10..0x14 delivered, size=5, o_overflow=0.
